// File: rtl/down_counter_timer_ctrl_if.sv
// Control/status bundle between a host and the countdown timer controller.
// The host (master) drives the commands and the timer (slave) drives the status.
interface down_counter_timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             pause;
   logic             periodic;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             paused;
   logic             done;

   modport master (
      output load_val, start, stop, pause, periodic,
      input  q, busy, paused, done
   );

   modport slave (
      input  load_val, start, stop, pause, periodic,
      output q, busy, paused, done
   );
endinterface

// File: rtl/down_counter_timer_ctrl.sv
// Programmable countdown timer: one-shot or auto-reload, prescaled ticks,
// with pause/resume and abort. All outputs are registered.
module down_counter_timer_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input logic                      clk,
   input logic                      rst,
   down_counter_timer_ctrl_if.slave bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             done_q, done_d;
   logic             busy_q, paused_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         q_q      <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         presc_q  <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
         busy_q   <= (state_d != IDLE);
         paused_q <= (state_d == PAUSE);
      end
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      presc_d  = presc_q;
      done_d   = 1'b0;

      if (bus.stop) begin
         // Abort keeps q visible; start in the same cycle is ignored.
         state_d = IDLE;
      end else if (bus.start) begin
         if (bus.load_val != '0) begin
            q_d      = bus.load_val;
            reload_d = bus.load_val;
            mode_d   = bus.periodic;
            presc_d  = '0;
            state_d  = RUN;
         end else begin
            q_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSE;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  // q<=1 treated as terminal so q can never wrap below zero.
                  if (q_q <= WIDTH'(1)) begin
                     done_d = 1'b1;
                     if (mode_q) begin
                        q_d = reload_q;
                     end else begin
                        q_d     = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     q_d = q_q - WIDTH'(1);
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            PAUSE: begin
               if (!bus.pause) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.q      = q_q;
   assign bus.busy   = busy_q;
   assign bus.paused = paused_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_down_counter_timer_ctrl.sv
// Drives two timers (prescale 1 and 2) with the same directed stimulus and checks
// them every cycle against an elapsed-tick model, plus hand-computed literals.
module tb_down_counter_timer_ctrl;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;

   int checks = 0;
   int errors = 0;
   bit en_cmp = 1'b0;

   always #5 clk = ~clk;

   down_counter_timer_ctrl_if #(.WIDTH(W)) if_a ();
   down_counter_timer_ctrl_if #(.WIDTH(W)) if_b ();

   assign if_a.load_val = load_val;
   assign if_a.start    = start;
   assign if_a.stop     = stop;
   assign if_a.pause    = pause;
   assign if_a.periodic = periodic;
   assign if_b.load_val = load_val;
   assign if_b.start    = start;
   assign if_b.stop     = stop;
   assign if_b.pause    = pause;
   assign if_b.periodic = periodic;

   down_counter_timer_ctrl #(.WIDTH(W), .PRESCALE(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   down_counter_timer_ctrl #(.WIDTH(W), .PRESCALE(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   // Model: while running, q follows from the number of un-paused cycles since start.
   int m_p[2] = '{1, 2};
   bit m_busy[2], m_pst[2], m_per[2], m_done[2];
   int m_act[2], m_load[2], m_qi[2];

   function automatic int exp_q(int i);
      int t;
      t = m_act[i] / m_p[i];
      if (!m_busy[i]) return m_qi[i];
      if (m_per[i]) return m_load[i] - (t % m_load[i]);
      return m_load[i] - t;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (rst) begin
            m_busy[i] = 0; m_pst[i] = 0; m_act[i] = 0;
            m_load[i] = 0; m_per[i] = 0; m_qi[i] = 0;
         end else if (stop) begin
            if (m_busy[i]) m_qi[i] = exp_q(i);
            m_busy[i] = 0; m_pst[i] = 0;
         end else if (start) begin
            if (load_val != 0) begin
               m_busy[i] = 1; m_pst[i] = 0; m_act[i] = 0;
               m_load[i] = int'(load_val); m_per[i] = periodic;
            end else begin
               m_qi[i] = 0; m_busy[i] = 0; m_pst[i] = 0; m_done[i] = 1;
            end
         end else if (m_busy[i] && !m_pst[i]) begin
            if (pause) begin
               m_pst[i] = 1;
            end else begin
               m_act[i]++;
               if (m_act[i] % m_p[i] == 0) begin
                  if (m_per[i]) begin
                     if ((m_act[i] / m_p[i]) % m_load[i] == 0) m_done[i] = 1;
                  end else if (m_act[i] / m_p[i] == m_load[i]) begin
                     m_done[i] = 1; m_busy[i] = 0; m_qi[i] = 0;
                  end
               end
            end
         end else if (m_busy[i] && m_pst[i] && !pause) begin
            m_pst[i] = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (en_cmp) begin
         chk("a.q", int'(if_a.q), exp_q(0));
         chk("a.busy", int'(if_a.busy), int'(m_busy[0]));
         chk("a.paused", int'(if_a.paused), int'(m_busy[0] && m_pst[0]));
         chk("a.done", int'(if_a.done), int'(m_done[0]));
         chk("b.q", int'(if_b.q), exp_q(1));
         chk("b.busy", int'(if_b.busy), int'(m_busy[1]));
         chk("b.paused", int'(if_b.paused), int'(m_busy[1] && m_pst[1]));
         chk("b.done", int'(if_b.done), int'(m_done[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_start(input int lv, input bit per);
      load_val = W'(lv); periodic = per; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic lit_a(input string name, input int q, input int b, input int d);
      chk({name, ".q"}, int'(if_a.q), q);
      chk({name, ".busy"}, int'(if_a.busy), b);
      chk({name, ".done"}, int'(if_a.done), d);
   endtask

   int q_hold;
   int pause_q[5] = '{4, 3, 2, 1, 0};
   int per_q[6]   = '{2, 1, 1, 2, 2, 1};
   int per_d[6]   = '{0, 0, 0, 1, 0, 0};

   initial begin
      cyc(2);
      lit_a("reset", 0, 0, 0);
      chk("reset.paused", int'(if_a.paused), 0);
      rst = 1'b0;
      en_cmp = 1'b1;

      // Reset mid-run.
      pulse_start(5, 0);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      lit_a("midrst", 0, 0, 0);
      rst = 1'b0;

      // One-shot 3,2,1,0 on prescale 1.
      pulse_start(3, 0);
      lit_a("os0", 3, 1, 0);
      cyc(1); lit_a("os1", 2, 1, 0);
      cyc(1); lit_a("os2", 1, 1, 0);
      cyc(1); lit_a("os3", 0, 0, 1);
      cyc(1); lit_a("os4", 0, 0, 0);
      cyc(4);

      // Periodic load 2 on prescale 2: q 2,2,1,1,2(done),2,1...
      pulse_start(2, 1);
      chk("per0.q", int'(if_b.q), 2);
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         chk($sformatf("per%0d.q", k + 1), int'(if_b.q), per_q[k]);
         chk($sformatf("per%0d.done", k + 1), int'(if_b.done), per_d[k]);
      end
      cyc(3);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      q_hold = int'(if_b.q);
      chk("perstop.busy", int'(if_b.busy), 0);
      cyc(3);
      chk("perstop.q", int'(if_b.q), q_hold);

      // Pause at q=4 for three sampled edges; done lands 6+4 edges after start.
      pulse_start(6, 0);
      cyc(2);
      lit_a("pz2", 4, 1, 0);
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk("pz.q", int'(if_a.q), 4);
         chk("pz.paused", int'(if_a.paused), 1);
      end
      pause = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         chk("pzrun.q", int'(if_a.q), pause_q[k]);
         chk("pzrun.done", int'(if_a.done), (k == 4) ? 1 : 0);
      end
      cyc(14);

      // Restart over a due terminal tick, then stop+start together.
      pulse_start(2, 0);
      cyc(1);
      lit_a("rs1", 1, 1, 0);
      pulse_start(9, 0);
      lit_a("rs9", 9, 1, 0);
      cyc(2);
      lit_a("rs7", 7, 1, 0);
      load_val = W'(4); stop = 1'b1; start = 1'b1;
      cyc(1);
      stop = 1'b0; start = 1'b0;
      lit_a("ss0", 7, 0, 0);
      cyc(1);
      lit_a("ss1", 7, 0, 0);

      // Zero load: one done pulse, never busy.
      pulse_start(0, 1);
      lit_a("z0", 0, 0, 1);
      cyc(1);
      lit_a("z1", 0, 0, 0);
      cyc(3);
      lit_a("z4", 0, 0, 0);

      // Pause held across a start: RUN first, PAUSE one cycle later.
      pause = 1'b1;
      pulse_start(3, 0);
      chk("sp0.paused", int'(if_a.paused), 0);
      chk("sp0.busy", int'(if_a.busy), 1);
      cyc(1);
      chk("sp1.paused", int'(if_a.paused), 1);
      chk("sp1.q", int'(if_a.q), 3);
      pause = 1'b0;
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
